// File: rtl/adder16_accumulator.sv
// adder16_accumulator: sums a frame of WIDTH-bit words arriving on a
// valid/ready stream. It counts carry-outs across the frame and presents
// the final sum plus the carry count on a valid/ready output.
//
// Optional build macro ACC_END_AROUND_CARRY_EN selects ones'-complement
// checksum mode. In that mode each carry-out is fed back as the next
// beat's carry-in, and one FOLD cycle adds the last pending carry back in.
// Without the macro the block is a plain modulo-2^WIDTH accumulator.
module adder16_accumulator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             busy
);

`ifdef ACC_END_AROUND_CARRY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FOLD = 2'd2,
    HOLD = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd3
  } state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] carries;
  logic [CNT_W-1:0] remaining;

  logic             beat;
  logic             cin;
  logic [WIDTH:0]   beat_total;
  logic [CNT_W-1:0] beat_carries;

`ifdef ACC_END_AROUND_CARRY_EN
  logic             pending;
  logic [WIDTH:0]   fold_total;
  logic [CNT_W-1:0] fold_carries;
`endif

  // Carry counter that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_ONE;
  endfunction

  // Adder datapath: one beat's sum/carry and, in checksum mode, the fold sum.
  always_comb begin
    beat = in_valid && in_ready;
    cin  = 1'b0;
`ifdef ACC_END_AROUND_CARRY_EN
    cin  = pending;
`endif
    beat_total   = {1'b0, acc} + {1'b0, in_data} + {{WIDTH{1'b0}}, cin};
    beat_carries = beat_total[WIDTH] ? sat_inc(carries) : carries;
`ifdef ACC_END_AROUND_CARRY_EN
    fold_total   = {1'b0, acc} + {{WIDTH{1'b0}}, pending};
    fold_carries = fold_total[WIDTH] ? sat_inc(carries) : carries;
`endif
  end

  // Frame control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      carries     <= '0;
      remaining   <= '0;
`ifdef ACC_END_AROUND_CARRY_EN
      pending     <= 1'b0;
`endif
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_carries <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            carries <= '0;
`ifdef ACC_END_AROUND_CARRY_EN
            pending <= 1'b0;
`endif
            busy    <= 1'b1;
            if (len != '0) begin
              remaining <= len;
              in_ready  <= 1'b1;
              state     <= ACC;
            end else begin
              out_sum     <= '0;
              out_carries <= '0;
              out_valid   <= 1'b1;
              state       <= HOLD;
            end
          end
        end

        ACC: begin
          if (beat) begin
            acc       <= beat_total[WIDTH-1:0];
            carries   <= beat_carries;
            remaining <= remaining - CNT_ONE;
`ifdef ACC_END_AROUND_CARRY_EN
            pending   <= beat_total[WIDTH];
`endif
            if (remaining == CNT_ONE) begin
              in_ready <= 1'b0;
`ifdef ACC_END_AROUND_CARRY_EN
              state    <= FOLD;
`else
              out_sum     <= beat_total[WIDTH-1:0];
              out_carries <= beat_carries;
              out_valid   <= 1'b1;
              state       <= HOLD;
`endif
            end
          end
        end

`ifdef ACC_END_AROUND_CARRY_EN
        FOLD: begin
          acc         <= fold_total[WIDTH-1:0];
          carries     <= fold_carries;
          pending     <= 1'b0;
          out_sum     <= fold_total[WIDTH-1:0];
          out_carries <= fold_carries;
          out_valid   <= 1'b1;
          state       <= HOLD;
        end
`endif

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder16_accumulator.sv
// tb_adder16_accumulator: directed and randomized frames for
// adder16_accumulator. Expected sums and carry counts come from whole-frame
// arithmetic on the word list. Honours ACC_END_AROUND_CARRY_EN like the design.
module tb_adder16_accumulator;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
`ifdef ACC_END_AROUND_CARRY_EN
  localparam int RESULT_LAT = 2;
`else
  localparam int RESULT_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_carries;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] frame_q[$];
  logic [WIDTH-1:0] exp_sum;
  logic [CNT_W-1:0] exp_carries;

  adder16_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .busy        (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Whole-frame reference. A plain sum wraps once per 2^16, so the carry
  // count is total/2^16. An end-around sum is the total reduced mod 0xFFFF,
  // and each end-around carry removes 0xFFFF from the total.
  function automatic void expected_result(output logic [WIDTH-1:0] sum,
                                          output logic [CNT_W-1:0] carries);
    longint total;
    longint c;
    longint r;
    total = 0;
    foreach (frame_q[i]) total += longint'(frame_q[i]);
`ifdef ACC_END_AROUND_CARRY_EN
    r = total % 65535;
    if (r == 0 && total != 0) r = 65535;
    c = (total - r) / 65535;
`else
    r = total % 65536;
    c = total / 65536;
`endif
    if (c > 255) c = 255;
    sum     = r[WIDTH-1:0];
    carries = c[CNT_W-1:0];
  endfunction

  // Runs one frame from frame_q starting at a negedge in IDLE and checks the result.
  task automatic applyStimulus(input int gap_min, input int gap_max);
    int n;
    int wait_cnt;
    n = frame_q.size();
    expected_result(exp_sum, exp_carries);
    start = 1'b1;
    len   = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      checkOutput("len0_out_valid", out_valid, 1);
      checkOutput("len0_in_ready", in_ready, 0);
    end else begin
      checkOutput("busy_after_start", busy, 1);
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, gap_min)) begin
          @(negedge clk);
          checkOutput("no_valid_in_gap", out_valid, 0);
        end
        in_valid = 1'b1;
        in_data  = frame_q[i];
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
          @(negedge clk);
          wait_cnt++;
        end
        if (!in_ready) begin
          checkOutput("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      for (int k = 1; k < RESULT_LAT; k++) begin
        checkOutput("out_valid_early", out_valid, 0);
        @(negedge clk);
      end
      checkOutput("out_valid_latency", out_valid, 1);
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      checkOutput("in_ready_after_frame", in_ready, 0);
    end
    checkOutput("out_sum", out_sum, exp_sum);
    checkOutput("out_carries", out_carries, exp_carries);
  endtask

  // Holds the result with out_ready low, pokes start, then releases it.
  task automatic releaseResult(input int hold_cycles);
    out_ready = 1'b0;
    for (int k = 0; k < hold_cycles; k++) begin
      if (k == 1) begin
        start = 1'b1;
        len   = 8'd5;
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_out_sum", out_sum, exp_sum);
      checkOutput("hold_out_carries", out_carries, exp_carries);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_out_valid", out_valid, 0);
    checkOutput("release_busy", busy, 0);
    checkOutput("release_in_ready", in_ready, 0);
    checkOutput("idle_keeps_sum", out_sum, exp_sum);
  endtask

  initial begin
    int n;
    int mode;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_sum", out_sum, 0);
    checkOutput("reset_out_carries", out_carries, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] three ones back-to-back, then held result");
    frame_q = '{16'h0001, 16'h0001, 16'h0001};
    applyStimulus(0, 0);
    checkOutput("t1_sum_const", out_sum, 16'h0003);
    releaseResult(5);

    $display("[TB] carry wrap 0xFFFF + 0x0001");
    frame_q = '{16'hFFFF, 16'h0001};
    applyStimulus(0, 0);
`ifdef ACC_END_AROUND_CARRY_EN
    checkOutput("t2_sum_const", out_sum, 16'h0001);
`else
    checkOutput("t2_sum_const", out_sum, 16'h0000);
`endif
    checkOutput("t2_carries_const", out_carries, 1);
    releaseResult(0);

    $display("[TB] gapped beats");
    frame_q = '{16'h1234, 16'h4321};
    applyStimulus(3, 3);
    checkOutput("t3_sum_const", out_sum, 16'h5555);
    releaseResult(1);

    $display("[TB] reset mid-frame");
    start = 1'b1;
    len   = 8'd3;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", in_ready, 0);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_out_sum", out_sum, 0);
    checkOutput("midreset_out_carries", out_carries, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_q = '{16'h0010};
    applyStimulus(0, 0);
    checkOutput("t6_sum_const", out_sum, 16'h0010);
    releaseResult(0);

    $display("[TB] empty frame");
    frame_q = {};
    applyStimulus(0, 0);
    releaseResult(2);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      n    = $urandom_range(12, 1);
      mode = $urandom_range(2, 0);
      frame_q = {};
      for (int i = 0; i < n; i++) begin
        case (mode)
          0:       frame_q.push_back(WIDTH'($urandom));
          1:       frame_q.push_back(16'hF000 | WIDTH'($urandom));
          default: frame_q.push_back(WIDTH'($urandom_range(255, 0)));
        endcase
      end
      applyStimulus(0, 2);
      releaseResult($urandom_range(3, 0));
    end

    $display("[TB] longest frame of all-ones words");
    frame_q = {};
    for (int i = 0; i < 255; i++) frame_q.push_back(16'hFFFF);
    applyStimulus(0, 0);
    releaseResult(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
